// File: rtl/mips8_div_pkg.sv
// Shared types and constants for the MIPS8 sequential divider.
// Holds the FSM state encoding and the default operand width.
package mips8_div_pkg;

   localparam int DIV_W     = 8;
   localparam int DIV_CNT_W = $clog2(DIV_W);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_e;

   // Iteration counter width for an n-bit divide; never narrower than 1 bit.
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/div_subtractor.sv
// Combinational W-bit subtractor a - b built as a + ~b + 1.
// borrow is the inverted carry out: high when b > a.
module div_subtractor #(
   parameter int W = 9
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] diff,
   output logic         borrow
);

   logic [W:0] sum;

   assign sum    = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
   assign diff   = sum[W-1:0];
   assign borrow = ~sum[W];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Signed mode divides magnitudes and fixes result signs on the final load.
module seq_divider
   import mips8_div_pkg::*;
#(
   parameter int N = DIV_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         signed_op,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_by_zero
);

   localparam int           CW   = cnt_width(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);
   localparam logic [N-1:0]  ONE  = N'(1);

   div_state_e    state;
   logic [N:0]    p;
   logic [N-1:0]  a;
   logic [N-1:0]  d;
   logic          q_neg;
   logic          r_neg;
   logic [CW-1:0] cnt;

   logic          dd_neg, dv_neg;
   logic [N-1:0]  dd_mag, dv_mag;
   logic [N:0]    p_sh, trial, p_nxt;
   logic [N-1:0]  a_nxt;
   logic          borrow, restore;

   // Operand magnitudes; the most-negative value maps onto itself as an unsigned magnitude.
   assign dd_neg = signed_op & dividend[N-1];
   assign dv_neg = signed_op & divisor[N-1];
   assign dd_mag = dd_neg ? (~dividend + ONE) : dividend;
   assign dv_mag = dv_neg ? (~divisor  + ONE) : divisor;

   assign p_sh = {p[N-1:0], a[N-1]};

   div_subtractor #(.W(N + 1)) u_sub (
      .a      (p_sh),
      .b      ({1'b0, d}),
      .diff   (trial),
      .borrow (borrow)
   );

   // A bit shifted out of P[N] means the trial subtraction cannot underflow.
   assign restore = borrow & ~p[N];

   always_comb begin
      p_nxt = restore ? p_sh : trial;
      a_nxt = {a[N-2:0], ~restore};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         cnt         <= '0;
         p           <= '0;
         a           <= '0;
         d           <= '0;
         q_neg       <= 1'b0;
         r_neg       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (divisor == '0) begin
                     state       <= DONE;
                     done        <= 1'b1;
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                  end else begin
                     state       <= RUN;
                     cnt         <= '0;
                     div_by_zero <= 1'b0;
                     p           <= '0;
                     a           <= dd_mag;
                     d           <= dv_mag;
                     q_neg       <= dd_neg ^ dv_neg;
                     r_neg       <= dd_neg;
                  end
               end
            end
            RUN: begin
               p   <= p_nxt;
               a   <= a_nxt;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state     <= DONE;
                  done      <= 1'b1;
                  quotient  <= q_neg ? (~a_nxt + ONE) : a_nxt;
                  remainder <= r_neg ? (~p_nxt[N-1:0] + ONE) : p_nxt[N-1:0];
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle restoring integer divider for the MIPS8 datapath. It is the inverse arithmetic path to the combinational N-bit adder.
- Produces quotient and remainder of two N-bit operands, signed or unsigned, one quotient bit per clock.
- The ALU/control FSM drives it through a start/busy/done handshake. Results feed the HI/LO-style result registers.

Parameters:
- N, 8, operand/result width in bits (N >= 2)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request a division; accepted only when busy=0
- signed_op  input  1  1 = two's-complement operands, 0 = unsigned
- dividend  input  N  numerator, sampled on accepted start
- divisor  input  N  denominator, sampled on accepted start
- busy  output  1  high from the cycle after acceptance through the done cycle
- done  output  1  one-cycle pulse; results valid
- quotient  output  N  registered quotient
- remainder  output  N  registered remainder
- div_by_zero  output  1  registered flag, valid with done

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous, active-low (rst_n).
- Reset (rst_n=0 at a clk edge):
  - state=IDLE.
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0.
  - Reset mid-operation aborts the division with no done pulse.
- States: IDLE, RUN, DONE. busy = (state != IDLE). done = (state == DONE).
- IDLE:
  - start=1 latches the operands and signed_op.
  - If divisor==0: next state DONE; quotient=all ones; remainder=dividend (raw, uncorrected); div_by_zero=1.
  - Otherwise: next state RUN; counter=0; div_by_zero=0.
  - Signed mode: operands are converted to magnitudes, and the result signs are stored as q_neg = sign(dividend) XOR sign(divisor) and r_neg = sign(dividend).
- RUN, one iteration per cycle:
  - Partial remainder P (N+1 bits) and shift register A.
  - {P,A} shifted left by 1; trial = P - D using the subtractor sub-module.
  - If no borrow: P = trial and A[0] = 1. Otherwise P is restored and A[0] = 0.
  - counter increments each iteration.
  - After iteration N-1 (counter==N-1), next state DONE. quotient/remainder registers load A/P[N-1:0], negated if q_neg/r_neg respectively.
- DONE: lasts exactly one cycle, then IDLE.
- Latency:
  - Start accepted at edge E0 -> done high in the cycle after edge E_N, so N+1 cycles for the normal path.
  - Divide-by-zero: done in the cycle after E0.
- Outputs hold their values until the next accepted start. They are not cleared on return to IDLE.
- start while busy=1 is ignored, including during the DONE cycle. The operands are not re-sampled.
- Signed overflow (most-negative / -1): magnitude arithmetic yields quotient = most-negative value (0x80 for N=8), remainder=0, div_by_zero=0. No trap.
- Truncation is toward zero; the remainder takes the sign of the dividend, and remainder magnitude < divisor magnitude.
- Unsigned mode ignores operand MSB semantics; no negation is applied.

Decomposition:
- Shared package mips8_div_pkg:
  - state enum (IDLE/RUN/DONE)
  - DIV_W default constant
  - counter width localparam ($clog2(N))
- One sub-module, div_subtractor: N+1-bit combinational a - b returning difference and borrow, implemented as a + ~b + 1. No other sub-modules; the sign conversion is inline.

Test Plan:
- Unsigned 100/7 (0x64/0x07): start for 1 cycle -> done exactly 9 cycles after the start edge; quotient=0x0E, remainder=0x02, div_by_zero=0; busy high 9 cycles.
- Signed -100/7 (0x9C/0x07, signed_op=1) -> quotient=0xF2 (-14), remainder=0xFE (-2). Also 100/-7 -> 0xF2 / 0x02.
- Divide-by-zero 0x55/0x00 -> done in the cycle after the start edge; quotient=0xFF, remainder=0x55, div_by_zero=1; then busy=0.
- Signed overflow 0x80/0xFF, signed_op=1 -> quotient=0x80, remainder=0x00, div_by_zero=0. Unsigned 0x80/0xFF -> quotient=0x00, remainder=0x80.
- Handshake: start 200/3, then pulse start with 9/9 on cycles 3 and 9 (the DONE cycle) -> single done, quotient=0x42, remainder=0x02. The second start is ignored, and the outputs hold after done.
- Reset mid-op: rst_n=0 at cycle 4 of a run -> next cycle busy=0, done=0, all outputs 0. A subsequent 255/16 -> quotient=0x0F, remainder=0x0F.
